// File: rtl/mdu_param.sv
// ---------------------------------------------------------------------------
// mdu_param -- iterative multiply/divide unit for the RISC-V M extension.
//
// Multiplies by shift-add, retiring MUL_BPC multiplier bits per cycle.
// Divides by restoring division, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration through a
// one-cycle preload. The result bus already carries the value selected
// by funct3, so the core needs no output mux.
//
// Parameters
//   XLEN     operand/result width (even, >= 8)
//   MUL_BPC  multiplier bits retired per cycle (1, 2 or 4; divides XLEN)
//
// Ports
//   clk      clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   start    request, sampled only while idle
//   flush    synchronous abort of any in-flight or pending operation
//   ack      core consumed result; clears done
//   funct3   M-extension operation select
//   a, b     rs1 / rs2 operands
//   busy     operation in flight
//   done     result valid; held until ack, flush or next accepted start
//   result   rd value for the latched funct3
// ---------------------------------------------------------------------------
module mdu_param #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic            ack,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / MUL_BPC;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   MUL_LAST = CW'(N - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } state_t;

    state_t            state_reg,   state_next;
    logic [2:0]        op_reg,      op_next;
    logic              neg_p_reg,   neg_p_next;    // negate product
    logic              neg_q_reg,   neg_q_next;    // negate quotient
    logic              neg_r_reg,   neg_r_next;    // negate remainder
    logic              fast_reg,    fast_next;     // quo_reg holds a final preload
    logic [CW-1:0]     cnt_reg,     cnt_next;
    logic [2*XLEN-1:0] mcand_reg,   mcand_next;
    logic [XLEN-1:0]   mplier_reg,  mplier_next;
    logic [2*XLEN-1:0] acc_reg,     acc_next;
    logic [XLEN-1:0]   quo_reg,     quo_next;      // dividend shifts out, quotient in
    logic [XLEN:0]     rem_reg,     rem_next;
    logic [XLEN-1:0]   divisor_reg, divisor_next;
    logic [XLEN-1:0]   result_reg,  result_next;
    logic              done_reg,    done_next;

    // Operand sign handling at accept time
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Multiply step: sum of the shifted multiplicand copies selected by the
    // low MUL_BPC multiplier bits.
    logic [2*XLEN-1:0] pp [MUL_BPC];
    logic [2*XLEN-1:0] pp_sum;

    // Divide step
    logic [XLEN+1:0]   trial;

    // Final correction
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // The top partial-remainder bit is only needed to size the subtract; it
    // never feeds the next shift because the remainder stays below b.
    logic              unused_rem_msb;
    assign unused_rem_msb = rem_reg[XLEN];

    generate
        for (genvar gi = 0; gi < MUL_BPC; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < MUL_BPC; i++) begin
            pp_sum = pp_sum + pp[i];
        end
    end

    always_comb begin
        a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg = a_sgn && a[XLEN-1];
        b_neg = b_sgn && b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    assign trial    = {1'b0, rem_reg[XLEN-1:0], quo_reg[XLEN-1]} - {2'b00, divisor_reg};
    assign prod_fix = neg_p_reg ? -acc_reg : acc_reg;
    assign quo_fix  = neg_q_reg ? -quo_reg : quo_reg;
    assign rem_fix  = neg_r_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        neg_p_next   = neg_p_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        fast_next    = fast_reg;
        cnt_next     = cnt_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        quo_next     = quo_reg;
        rem_next     = rem_reg;
        divisor_next = divisor_reg;
        result_next  = result_reg;
        done_next    = done_reg;

        // ack only ever clears done; a FIN on the same edge sets it again
        // below, since that ack refers to the previous result.
        if (ack) begin
            done_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    op_next      = funct3;
                    done_next    = 1'b0;
                    cnt_next     = '0;
                    neg_p_next   = a_neg ^ b_neg;
                    neg_q_next   = a_neg ^ b_neg;
                    neg_r_next   = a_neg;
                    fast_next    = 1'b0;
                    mcand_next   = {{XLEN{1'b0}}, a_mag};
                    mplier_next  = b_mag;
                    acc_next     = '0;
                    quo_next     = a_mag;
                    rem_next     = '0;
                    divisor_next = b_mag;
                    if (!funct3[2]) begin
                        state_next = ST_MUL;
                    end else if (b == '0) begin
                        state_next = ST_FIN;
                        fast_next  = 1'b1;
                        quo_next   = funct3[1] ? a : '1;
                    end else if (!funct3[0] && (a == MOST_NEG) && (b == '1)) begin
                        state_next = ST_FIN;
                        fast_next  = 1'b1;
                        quo_next   = funct3[1] ? '0 : a;
                    end else begin
                        state_next = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                acc_next    = acc_reg + pp_sum;
                mcand_next  = mcand_reg << MUL_BPC;
                mplier_next = mplier_reg >> MUL_BPC;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == MUL_LAST) begin
                    state_next = ST_FIN;
                end
            end
            ST_DIV: begin
                if (!trial[XLEN+1]) begin
                    rem_next = trial[XLEN:0];
                end else begin
                    rem_next = {rem_reg[XLEN-1:0], quo_reg[XLEN-1]};
                end
                quo_next = {quo_reg[XLEN-2:0], ~trial[XLEN+1]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == DIV_LAST) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                if (fast_reg) begin
                    result_next = quo_reg;
                end else begin
                    case (op_reg)
                        3'b000:                  result_next = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011:  result_next = prod_fix[2*XLEN-1:XLEN];
                        3'b100, 3'b101:          result_next = quo_fix;
                        default:                 result_next = rem_fix;
                    endcase
                end
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Flush overrides everything, including a same-edge start or FIN.
        if (flush) begin
            state_next  = ST_IDLE;
            done_next   = 1'b0;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            neg_p_reg   <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            fast_reg    <= 1'b0;
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            neg_p_reg   <= neg_p_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            fast_reg    <= fast_next;
            cnt_reg     <= cnt_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            quo_reg     <= quo_next;
            rem_reg     <= rem_next;
            divisor_reg <= divisor_next;
            result_reg  <= result_next;
            done_reg    <= done_next;
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = done_reg;
    assign result = result_reg;

endmodule
